// File: rtl/btn_event_ctrl.sv
// Push-button input stage for the memory game: per-line sync, debounce,
// sticky press events (RW1C) and a wrapping press counter on a polled bus.
// Define BTN_EVENT_RELEASE_EN to also latch release events in EVENTS[2*N_BTN-1:N_BTN].
module btn_event_ctrl #(
    parameter int N_BTN      = 4,
    parameter int DEB_CYCLES = 1000000,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BTN-1:0]  btn_in,
    input  logic              sel,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [N_BTN-1:0]  btn_db,
    output logic              evt_pend
);

`ifdef BTN_EVENT_RELEASE_EN
    localparam int EVT_W = 2 * N_BTN;
`else
    localparam int EVT_W = N_BTN;
`endif

    localparam logic [19:0] DEB_LAST = 20'(DEB_CYCLES - 1);

    localparam logic [1:0] ADDR_STATE  = 2'd0;
    localparam logic [1:0] ADDR_EVENTS = 2'd1;
    localparam logic [1:0] ADDR_PCNT   = 2'd2;

    logic [N_BTN-1:0]  r_s1;
    logic [N_BTN-1:0]  r_s2;
    logic [N_BTN-1:0]  r_db;
    logic [N_BTN-1:0]  r_db_prev;
    logic [19:0]       r_cnt [N_BTN];
    logic [EVT_W-1:0]  r_events;
    logic [7:0]        r_pcnt;

    logic [N_BTN-1:0]  w_rise;
    logic [N_BTN-1:0]  w_fall;
    logic [EVT_W-1:0]  w_evt_set;
    logic [EVT_W-1:0]  w_evt_clr;
    logic [7:0]        w_rise_cnt;
    logic              w_bus_wr;
    logic              w_pcnt_clr;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unused_data;

    // Two-flop synchroniser; the raw pins are fully asynchronous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= btn_in;
            r_s2 <= r_s1;
        end
    end

    // A new level is accepted only after it has been seen for DEB_CYCLES
    // consecutive cycles; any return to the current level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (r_s2[i] != r_db[i]) begin
                    if (r_cnt[i] == DEB_LAST) begin
                        r_db[i]  <= r_s2[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 20'd1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_prev <= '0;
        end else begin
            r_db_prev <= r_db;
        end
    end

    assign w_rise = r_db & ~r_db_prev;
    assign w_fall = ~r_db & r_db_prev;

`ifdef BTN_EVENT_RELEASE_EN
    assign w_evt_set = {w_fall, w_rise};
`else
    assign w_evt_set = w_rise;
    logic w_unused_fall;
    assign w_unused_fall = |w_fall;
`endif

    assign w_bus_wr   = sel & we;
    assign w_evt_clr  = (w_bus_wr && addr == ADDR_EVENTS) ? data_in[EVT_W-1:0] : '0;
    assign w_pcnt_clr = w_bus_wr && (addr == ADDR_PCNT);

    always_comb begin
        w_rise_cnt = 8'd0;
        for (int i = 0; i < N_BTN; i++) begin
            w_rise_cnt = w_rise_cnt + {7'd0, w_rise[i]};
        end
    end

    // A set in the same cycle as its W1C wins, so no press is ever lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_events <= '0;
        end else begin
            r_events <= (r_events & ~w_evt_clr) | w_evt_set;
        end
    end

    // Clearing keeps this cycle's increments so simultaneous presses still count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (w_pcnt_clr) begin
            r_pcnt <= w_rise_cnt;
        end else begin
            r_pcnt <= r_pcnt + w_rise_cnt;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (sel) begin
            case (addr)
                ADDR_STATE:  w_rdata[N_BTN-1:0] = r_db;
                ADDR_EVENTS: w_rdata[EVT_W-1:0] = r_events;
                ADDR_PCNT:   w_rdata[7:0]       = r_pcnt;
                default:     w_rdata            = '0;
            endcase
        end
    end

    assign w_unused_data = &{1'b0, data_in[DATA_W-1:EVT_W]};

    assign data_out = w_rdata;
    assign btn_db   = r_db;
    assign evt_pend = |r_events;

endmodule
